// File: rtl/iopmp_err_capture_pkg.sv
// Shared types and constants for the IOPMP error-capture block.
// Covers the access type, error config, error record layout and encodings.
package iopmp_err_capture_pkg;

    localparam int unsigned SourceWidth = 8;
    localparam int unsigned DefaultCntW = 8;

    localparam logic [1:0] ERR_TTYPE_READ      = 2'd1;
    localparam logic [1:0] ERR_TTYPE_WRITE     = 2'd2;
    localparam logic [2:0] ERR_ETYPE_ILL_READ  = 3'd1;
    localparam logic [2:0] ERR_ETYPE_ILL_WRITE = 3'd2;

    typedef enum logic {
        IOPMP_ACC_READ  = 1'b0,
        IOPMP_ACC_WRITE = 1'b1
    } iopmp_req_e;

    typedef struct packed {
        logic ie;
    } err_cfg_t;

    typedef struct packed {
        logic       v;
        logic [1:0] ttype;
        logic [2:0] etype;
    } err_info_t;

endpackage

// File: rtl/iopmp_err_capture_rr_arb.sv
// Combinational round-robin arbiter.
// Grants the first request at or after the pointer, wrapping around.
module iopmp_rr_arb #(
    parameter int unsigned N    = 2,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [IdxW-1:0] gnt_idx_o,
    output logic            gnt_valid_o
);

    int unsigned cand;
    logic        found;

    always_comb begin
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = (32'(ptr_i) + i) % N;
            if (!found && req_i[cand]) begin
                found     = 1'b1;
                gnt_idx_o = IdxW'(cand);
            end
        end
    end

    assign gnt_valid_o = |req_i;

endmodule

// File: rtl/iopmp_err_capture.sv
// Latches the first denied transaction into a single error record, counts
// violations lost while the record is held, and drives the IOPMP interrupt.
module iopmp_err_capture
    import iopmp_err_capture_pkg::*;
#(
    parameter int unsigned IOPMPNumChan = 2,
    parameter int unsigned AddrW        = 34,
    parameter int unsigned CntW         = DefaultCntW
) (
    input  logic                   clk,
    input  logic                   rst_ni,
    input  logic [IOPMPNumChan-1:0] viol_valid_i,
    input  logic [AddrW-1:0]       viol_addr_i   [IOPMPNumChan],
    input  iopmp_req_e             viol_access_i [IOPMPNumChan],
    input  logic [SourceWidth-1:0] viol_rrid_i   [IOPMPNumChan],
    input  err_cfg_t               err_cfg_i,
    input  logic                   clr_i,
    output err_info_t              err_info_o,
    output logic [AddrW-1:0]       err_reqaddr_o,
    output logic [SourceWidth-1:0] err_reqid_o,
    output logic [CntW-1:0]        err_svc_o,
    output logic                   irq_o
);

    localparam int unsigned IdxW = (IOPMPNumChan > 1) ? $clog2(IOPMPNumChan) : 1;
    localparam int unsigned SumW = CntW + $clog2(IOPMPNumChan) + 1;
    localparam logic [SumW-1:0] CntMax = {{(SumW - CntW){1'b0}}, {CntW{1'b1}}};

    typedef enum logic {
        StEmpty,
        StFull
    } state_e;

    state_e                 state_q;
    logic [IdxW-1:0]        ptr_q;
    logic [AddrW-1:0]       addr_q;
    logic [SourceWidth-1:0] rrid_q;
    logic [1:0]             ttype_q;
    logic [2:0]             etype_q;
    logic [CntW-1:0]        svc_q;
    logic                   irq_q;

    logic [IdxW-1:0] gnt_idx;
    logic            any_valid;

    iopmp_rr_arb #(
        .N    (IOPMPNumChan),
        .IdxW (IdxW)
    ) u_arb (
        .req_i       (viol_valid_i),
        .ptr_i       (ptr_q),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (any_valid)
    );

    logic [SumW-1:0] pop;
    logic [SumW-1:0] svc_base;
    logic [SumW-1:0] svc_sum;
    logic [CntW-1:0] svc_next;
    logic            is_full;
    logic            clr_eff;
    logic            capture;
    logic            v_next;
    logic [IdxW-1:0] ptr_next;

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < IOPMPNumChan; i++) begin
            pop = pop + SumW'(viol_valid_i[i]);
        end
    end

    // A clear in the same cycle as a violation frees the record before arbitration.
    always_comb begin
        is_full  = (state_q == StFull);
        clr_eff  = is_full & clr_i;
        capture  = (~is_full | clr_i) & any_valid;
        v_next   = capture | (is_full & ~clr_i);
        svc_base = clr_eff ? '0 : SumW'(svc_q);
        svc_sum  = svc_base + pop - SumW'(capture);
        svc_next = (svc_sum > CntMax) ? CntMax[CntW-1:0] : svc_sum[CntW-1:0];
        ptr_next = (gnt_idx == IdxW'(IOPMPNumChan - 1)) ? '0 : gnt_idx + IdxW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state_q <= StEmpty;
            ptr_q   <= '0;
            addr_q  <= '0;
            rrid_q  <= '0;
            ttype_q <= '0;
            etype_q <= '0;
            svc_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= v_next ? StFull : StEmpty;
            svc_q   <= svc_next;
            irq_q   <= v_next & err_cfg_i.ie;
            if (capture) begin
                ptr_q  <= ptr_next;
                addr_q <= viol_addr_i[gnt_idx];
                rrid_q <= viol_rrid_i[gnt_idx];
                if (viol_access_i[gnt_idx] == IOPMP_ACC_WRITE) begin
                    ttype_q <= ERR_TTYPE_WRITE;
                    etype_q <= ERR_ETYPE_ILL_WRITE;
                end else begin
                    ttype_q <= ERR_TTYPE_READ;
                    etype_q <= ERR_ETYPE_ILL_READ;
                end
            end
        end
    end

    assign err_info_o    = {state_q == StFull, ttype_q, etype_q};
    assign err_reqaddr_o = addr_q;
    assign err_reqid_o   = rrid_q;
    assign err_svc_o     = svc_q;
    assign irq_o         = irq_q;

endmodule
